bconv_frame_engine: RTL and testbench
=====================================

// Module: bconv_frame_engine
// PURPOSE
//  Multi-image 3x3 binary (+1/-1) convolution engine, the parametrised successor of the fixed 4x4 single-window block.
//  Streams N x N images (3 <= N <= MAX_DIM) one row per input-SRAM word and convolves each with a 9-bit kernel.
//  Writes one (N-2)-bit sign-thresholded feature row per output-SRAM word, and loops over images until a sentinel.
//  Sits between the testbench/top controller (dut_run/dut_busy) and the input, weight and output SRAMs.
// PARAMETERS
//  DATA_W   16  SRAM word width; also the row-buffer width
//  ADDR_W   12  SRAM address width
//  MAX_DIM  16  largest legal N; must be <= DATA_W
//  KERNEL    3  kernel edge; only 3 is supported, held here for the package constant
// PORTS
//  clk                    in   1       single clock, rising edge
//  reset                  in   1       synchronous, active-high
//  dut_run                in   1       start pulse; sampled in IDLE only
//  dut_busy               out  1       high from the cycle after dut_run is accepted until the run ends
//  dut_sram_read_address  out  ADDR_W  input-SRAM read address
//  sram_dut_read_data     in   DATA_W  input-SRAM data, 1 cycle after the address
//  dut_wmem_read_address  out  ADDR_W  weight-SRAM read address
//  wmem_dut_read_data     in   DATA_W  weight data, 1 cycle after the address; bits [8:0] are used
//  dut_sram_write_address out  ADDR_W  output-SRAM write address
//  dut_sram_write_data    out  DATA_W  feature row
//  dut_sram_write_enable  out  1       single-cycle write strobe
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; read/write pointers 0; row buffer cleared. Reset mid-run aborts the run
//    immediately; no further write strobe occurs after the reset cycle.
//  - Input layout: word p holds N, followed by N row words. Row bit c = column c. The next image's N word follows
//    the last row. N == 16'hFFFF is the sentinel and ends the run.
//  - Weight layout: bit 3*r+c = kernel row r, column c. Bit 1 = +1, bit 0 = -1.
//  - Output bit j of feature row i = 1 iff the 3x3 window at rows i..i+2, columns j..j+2 has >= 5 XNOR matches
//    with the kernel (sum >= 0; the sum is never 0). Bits [DATA_W-1:N-2] = 0.
//  - Output addresses start at 0 per run and increment once per written row, continuously across images.
//  - FSM: IDLE -> RD_W -> RD_DIM -> CHK -> FILL (3 rows) -> WR -> SHIFT (next row) -> WR ... -> RD_DIM.
//    CHK on the sentinel -> DONE -> IDLE with dut_busy low.
//  - Write count per image is N-2. dut_sram_write_enable pulses exactly 1 cycle per row; the address is valid
//    in the same cycle as the strobe.
//  - Edge cases:
//    - N < 3: skip N rows, no writes, continue with the next image.
//    - N > MAX_DIM (and not the sentinel): go to DONE with no writes for this image.
//    - Read pointer reaching 2^ADDR_W-1 before the sentinel: treated as the sentinel.
//    - Output pointer wrap: not protected; it wraps modulo 2^ADDR_W.
//  - dut_run while busy is ignored. dut_run in the DONE cycle is ignored; only IDLE accepts it.
//  - dut_busy rises 1 cycle after dut_run is accepted and falls in the cycle DONE -> IDLE.
// CONFIGURATION
//  BCONV_WEIGHT_PER_IMAGE_EN defined:
//    - image k (0-based, counting skipped images) re-reads its kernel from wmem address k in RD_DIM.
//  Undefined:
//    - the kernel is read once from wmem address 0 per run and reused for every image.
// STRUCTURE
//  - Package bconv_pkg:
//    - state enum
//    - SENTINEL = 16'hFFFF
//    - KERNEL = 3
//    - MATCH_THRESH = 5
//    - WEIGHT_BITS = 9
//  - Sub-module bconv_row_window: 3-row shift buffer (DATA_W bits each, load/shift/clear). Combinationally
//    produces all MAX_DIM-2 window bits via XNOR + popcount, masked to N-2.
//  - The top level holds the FSM, address counters, image counter and write register.
// TESTING
//  - 4x4 image, all rows 16'h000F, weight 9'h1FF -> 2 writes: addr0 = 16'h0003, addr1 = 16'h0003; then busy falls.
//  - Same image, weight 9'h000 -> addr0 = addr1 = 16'h0000; a checkerboard image (rows 5,A,5,A) with kernel
//    9'h155 -> 16'h0001 / 16'h0002 per the golden model.
//  - Two images back to back, N=4 then N=5, then sentinel -> writes at addrs 0,1 then 2,3,4; exactly 5 strobes.
//  - Image N=2 followed by N=3 -> no writes for the first image; 1 write at addr0 with (N-2)=1 valid bit.
//  - Sentinel at word 0 -> busy high for a few cycles, zero write strobes, busy falls, returns to IDLE.
//  - Reset asserted after the first write of a 5x5 image -> outputs 0 the next cycle, no more strobes.
//    A new dut_run restarts writing at addr0.
//  - Macro defined, two 4x4 images with kernels 9'h1FF / 9'h000 at wmem 0/1 -> 16'h0003,16'h0003,16'h0000,16'h0000;
//    undefined -> all four 16'h0003.

Source files
------------

// File: rtl/bconv_pkg.sv
// Shared types and constants for the binary 3x3 convolution frame engine.
// Holds the engine state encoding and the match-count helper.
package bconv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_W,
    S_RD_DIM,
    S_CHK,
    S_FILL,
    S_WR,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [15:0] SENTINEL = 16'hFFFF;
  localparam int KERNEL = 3;
  localparam int MATCH_THRESH = 5;
  localparam int WEIGHT_BITS = 9;

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/bconv_row_window.sv
// Three-row shift buffer plus all 3x3 XNOR/popcount window decisions.
// Window bit j covers columns j..j+2 and is masked to the active width.
module bconv_row_window
  import bconv_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_DIM = 16,
  parameter int DIM_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] row_i,
  input  logic [8:0]        kernel_i,
  input  logic [DIM_W-1:0]  dim_i,
  output logic [DATA_W-1:0] win_o
);

  logic [DATA_W-1:0] r0_q;
  logic [DATA_W-1:0] r1_q;
  logic [DATA_W-1:0] r2_q;

  // New rows enter at the bottom; r0 is always the window's top row.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
    end else if (shift_i) begin
      r0_q <= r1_q;
      r1_q <= r2_q;
      r2_q <= row_i;
    end
  end

  always_comb begin
    logic [8:0] w;
    logic [8:0] m;
    win_o = '0;
    w = '0;
    m = '0;
    for (int j = 0; j < MAX_DIM - 2; j++) begin
      w = {r2_q[j+:3], r1_q[j+:3], r0_q[j+:3]};
      m = ~(w ^ kernel_i);
      if ((popcnt9(m) >= 4'(MATCH_THRESH)) && (j + 2 < int'(dim_i))) begin
        win_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bconv_frame_engine.sv
// Multi-image 3x3 binary convolution engine: FSM, pointers, write register.
// BCONV_WEIGHT_PER_IMAGE_EN selects a per-image kernel at wmem[image index].
module bconv_frame_engine
  import bconv_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int MAX_DIM = 16,
  parameter int KERNEL_SZ = KERNEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] img_q, img_d;
  logic [DIM_W-1:0]  dim_q, dim_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [8:0]        kernel_q, kernel_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              clr;
  logic              shift;
  logic [DATA_W-1:0] win;
  logic              unused_wbits;

  assign unused_wbits = ^{wmem_dut_read_data[DATA_W-1:WEIGHT_BITS], KERNEL_SZ[0]};

  bconv_row_window #(
    .DATA_W  (DATA_W),
    .MAX_DIM (MAX_DIM),
    .DIM_W   (DIM_W)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (clr),
    .shift_i  (shift),
    .row_i    (sram_dut_read_data),
    .kernel_i (kernel_q),
    .dim_i    (dim_q),
    .win_o    (win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      img_q    <= '0;
      dim_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      kernel_q <= '0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      img_q    <= img_d;
      dim_q    <= dim_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      kernel_q <= kernel_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    img_d    = img_q;
    dim_d    = dim_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    kernel_d = kernel_q;
    busy_d   = busy_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    clr      = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dut_run) begin
          state_d  = S_RD_W;
          busy_d   = 1'b1;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          img_d    = '0;
        end
      end
      S_RD_W: begin
        state_d = S_RD_DIM;
      end
      S_RD_DIM: begin
`ifndef BCONV_WEIGHT_PER_IMAGE_EN
        if (img_q == '0) begin
          kernel_d = wmem_dut_read_data[8:0];
        end
`endif
        // The last address can never hold a complete image.
        if (rd_ptr_q == '1) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_CHK;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      S_CHK: begin
`ifdef BCONV_WEIGHT_PER_IMAGE_EN
        kernel_d = wmem_dut_read_data[8:0];
`endif
        if (sram_dut_read_data == DATA_W'(SENTINEL)) begin
          state_d = S_DONE;
        end else if (sram_dut_read_data > DATA_W'(MAX_DIM)) begin
          state_d = S_DONE;
        end else if (sram_dut_read_data < DATA_W'(KERNEL)) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(sram_dut_read_data[1:0]);
          img_d    = img_q + 1'b1;
          state_d  = S_RD_DIM;
        end else begin
          dim_d   = sram_dut_read_data[DIM_W-1:0];
          row_d   = '0;
          cnt_d   = '0;
          clr     = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // Reads issue on counts 0..2; each row lands one count later.
        if (cnt_q != 2'd3) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (cnt_q != 2'd0) begin
          shift = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 2'd3) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        we_d     = 1'b1;
        waddr_d  = wr_ptr_q;
        wdata_d  = win;
        wr_ptr_d = wr_ptr_q + 1'b1;
        row_d    = row_q + 1'b1;
        cnt_d    = '0;
        if (row_q + DIM_W'(1) == dim_q - DIM_W'(2)) begin
          img_d   = img_q + 1'b1;
          state_d = S_RD_DIM;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 2'd0) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d    = 2'd1;
        end else begin
          shift   = 1'b1;
          cnt_d   = '0;
          state_d = S_WR;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dut_busy               = busy_q;
  assign dut_sram_read_address  = rd_ptr_q;
`ifdef BCONV_WEIGHT_PER_IMAGE_EN
  assign dut_wmem_read_address  = img_q;
`else
  assign dut_wmem_read_address  = '0;
`endif
  assign dut_sram_write_address = waddr_q;
  assign dut_sram_write_data    = wdata_q;
  assign dut_sram_write_enable  = we_q;

endmodule

// File: tb/tb_bconv_frame_engine.sv
// Directed scoreboard bench for bconv_frame_engine with SRAM models.
// Expected rows come from a reference window model and fixed constants.
module tb_bconv_frame_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic [11:0] raddr;
  logic [15:0] rdata = '0;
  logic [11:0] wmaddr;
  logic [15:0] wmdata = '0;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic        we;

  logic [15:0] imem [0:4095];
  logic [15:0] wmem [0:4095];

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];

  logic [11:0] obs_a [0:255];
  logic [15:0] obs_d [0:255];
  int obs_n = 0;

  int n_run = 0;
  int n_fail = 0;
  int rd_idx = 0;
  int wp = 0;
  int optr = 0;
  int base = 0;
  logic [15:0] rows [16];

  bconv_frame_engine u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (raddr),
    .sram_dut_read_data     (rdata),
    .dut_wmem_read_address  (wmaddr),
    .wmem_dut_read_data     (wmdata),
    .dut_sram_write_address (waddr),
    .dut_sram_write_data    (wdata),
    .dut_sram_write_enable  (we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata  <= imem[raddr];
    wmdata <= wmem[wmaddr];
  end

  always @(negedge clk) begin
    if (we && obs_n < 256) begin
      obs_a[obs_n] = waddr;
      obs_d[obs_n] = wdata;
      obs_n = obs_n + 1;
    end
  end

  function automatic logic [15:0] gold(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] c,
                                       input int n,
                                       input logic [8:0] k);
    logic [15:0] o;
    logic [15:0] rw;
    int m;
    o = '0;
    for (int j = 0; j < n - 2; j++) begin
      m = 0;
      for (int r = 0; r < 3; r++) begin
        rw = (r == 0) ? a : ((r == 1) ? b : c);
        for (int cc = 0; cc < 3; cc++) begin
          if (rw[j+cc] == k[3*r+cc]) m++;
        end
      end
      o[j] = (m >= 5);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic fill_rows(input logic [15:0] v);
    for (int i = 0; i < 16; i++) rows[i] = v;
  endtask

  task automatic set_w(input logic [8:0] k);
    for (int i = 0; i < 8; i++) wmem[i] = {7'd0, k};
  endtask

  task automatic put_img(input int n, input logic [8:0] k, input int npush);
    exp_t e;
    imem[wp] = 16'(n);
    for (int i = 0; i < n; i++) imem[wp+1+i] = rows[i];
    wp = wp + n + 1;
    for (int i = 0; i < n - 2 && i < npush; i++) begin
      e.a = 12'(optr);
      e.d = gold(rows[i], rows[i+1], rows[i+2], n, k);
      exp_q.push_back(e);
      optr++;
    end
  endtask

  task automatic put_sent();
    imem[wp] = 16'hFFFF;
  endtask

  task automatic start_img();
    wp = 0;
    optr = 0;
    base = obs_n;
  endtask

  task automatic do_run(input string tag);
    int k;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    chk({tag, "_busy_rise"}, 32'(dut_busy), 32'd1);
    k = 0;
    while (dut_busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_busy_fall"}, 32'(dut_busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (rd_idx < obs_n) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $error("FAIL %s_extra: observed write %h/%h expected none",
               tag, obs_a[rd_idx], obs_d[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_addr"}, 32'(obs_a[rd_idx]), 32'(e.a));
        chk({tag, "_data"}, 32'(obs_d[rd_idx]), 32'(e.d));
      end
      rd_idx++;
    end
    chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    logic [8:0] k2;
    for (int i = 0; i < 4096; i++) begin
      imem[i] = 16'hFFFF;
      wmem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dut_busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_wmaddr", 32'(wmaddr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 4x4 of 0xF with all +1 kernel
    start_img();
    set_w(9'h1FF);
    fill_rows(16'h000F);
    put_img(4, 9'h1FF, 16);
    put_sent();
    do_run("t1");
    chk("t1_cnt", 32'(obs_n - base), 32'd2);
    chk("t1_row0", 32'(obs_d[base]), 32'h0003);
    chk("t1_row1", 32'(obs_d[base+1]), 32'h0003);
    drain("t1");

    // same image, all -1 kernel
    start_img();
    set_w(9'h000);
    put_img(4, 9'h000, 16);
    put_sent();
    do_run("t2");
    chk("t2_cnt", 32'(obs_n - base), 32'd2);
    drain("t2");

    // checkerboard with kernel 0x155
    start_img();
    set_w(9'h155);
    rows[0] = 16'h5; rows[1] = 16'hA; rows[2] = 16'h5; rows[3] = 16'hA;
    put_img(4, 9'h155, 16);
    put_sent();
    do_run("t3");
    chk("t3_row0", 32'(obs_d[base]), 32'h0001);
    chk("t3_row1", 32'(obs_d[base+1]), 32'h0002);
    drain("t3");

    // N=4 then N=5 back to back
    start_img();
    set_w(9'h1FF);
    fill_rows(16'h000F);
    put_img(4, 9'h1FF, 16);
    fill_rows(16'h001F);
    put_img(5, 9'h1FF, 16);
    put_sent();
    do_run("t4");
    chk("t4_cnt", 32'(obs_n - base), 32'd5);
    chk("t4_last_addr", 32'(obs_a[base+4]), 32'd4);
    drain("t4");

    // N=2 skipped, then N=3 yields one bit
    start_img();
    set_w(9'h1FF);
    fill_rows(16'h0007);
    put_img(2, 9'h1FF, 16);
    put_img(3, 9'h1FF, 16);
    put_sent();
    do_run("t5");
    chk("t5_cnt", 32'(obs_n - base), 32'd1);
    chk("t5_row0", 32'(obs_d[base]), 32'h0001);
    drain("t5");

    // sentinel at word 0
    start_img();
    put_sent();
    do_run("t6");
    chk("t6_cnt", 32'(obs_n - base), 32'd0);
    drain("t6");

    // oversize image ends the run silently
    start_img();
    imem[0] = 16'd17;
    for (int i = 1; i < 19; i++) imem[i] = 16'hFFF0;
    do_run("t7");
    chk("t7_cnt", 32'(obs_n - base), 32'd0);
    drain("t7");

    // reset after first write of a 5x5 image
    start_img();
    set_w(9'h1FF);
    fill_rows(16'h001F);
    put_img(5, 9'h1FF, 1);
    put_sent();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    k = 0;
    while (obs_n == base && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("t8_first_seen", 32'(obs_n - base), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t8_rst_we", 32'(we), 32'd0);
    chk("t8_rst_busy", 32'(dut_busy), 32'd0);
    chk("t8_rst_waddr", 32'(waddr), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t8_no_more", 32'(obs_n - base), 32'd1);
    drain("t8");
    start_img();
    put_img(5, 9'h1FF, 16);
    put_sent();
    do_run("t8b");
    chk("t8b_first_addr", 32'(obs_a[base]), 32'd0);
    drain("t8b");

    // two 4x4 images with different kernels at wmem 0/1
    start_img();
    wmem[0] = 16'h01FF;
    wmem[1] = 16'h0000;
`ifdef BCONV_WEIGHT_PER_IMAGE_EN
    k2 = 9'h000;
`else
    k2 = 9'h1FF;
`endif
    fill_rows(16'h000F);
    put_img(4, 9'h1FF, 16);
    put_img(4, k2, 16);
    put_sent();
    do_run("t9");
    chk("t9_cnt", 32'(obs_n - base), 32'd4);
    chk("t9_row2", 32'(obs_d[base+2]), (k2 == 9'h000) ? 32'h0 : 32'h3);
    drain("t9");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
